// File: rtl/alu_issue_decoder.sv
// RV32I ALU issue stage: decodes inst/operands into ALU A/B/control behind a registered 2-entry skid buffer.
// Define ALU_ILLEGAL_TRAP_EN to add a sticky trap (trap/trap_clr ports) that stalls the stage once an illegal entry issues.
module alu_issue_decoder #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      inst,
    input  logic [XLEN-1:0]  rs1_data,
    input  logic [XLEN-1:0]  rs2_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  alu_a,
    output logic [XLEN-1:0]  alu_b,
    output logic [3:0]       alu_ctrl,
    output logic [TAG_W-1:0] rd_tag,
    output logic             is_branch,
    output logic             br_ne,
`ifdef ALU_ILLEGAL_TRAP_EN
    output logic             trap,
    input  logic             trap_clr,
`endif
    output logic             illegal
);

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110
    } alu_op_e;

    typedef enum logic [6:0] {
        OPC_REG    = 7'b0110011,
        OPC_IMM    = 7'b0010011,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_BRANCH = 7'b1100011
    } opcode_e;

    typedef struct packed {
        logic [XLEN-1:0]  a;
        logic [XLEN-1:0]  b;
        alu_op_e          op;
        logic [TAG_W-1:0] tag;
        logic             is_branch;
        logic             br_ne;
        logic             illegal;
    } entry_t;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic            dec_legal;
    entry_t          dec;
    logic            unused_rs_fields;

    assign opcode           = inst[6:0];
    assign funct3           = inst[14:12];
    assign funct7           = inst[31:25];
    assign imm_i            = {{(XLEN-12){inst[31]}}, inst[31:20]};
    assign imm_s            = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
    assign unused_rs_fields = ^inst[19:15];

    // Decode is fully combinational; anything not recognised collapses to a zeroed AND entry flagged illegal.
    always_comb begin
        dec       = '0;
        dec.op    = ALU_ADD;
        dec.tag   = inst[7 +: TAG_W];
        dec_legal = 1'b0;
        case (opcode)
            OPC_REG: begin
                dec.a = rs1_data;
                dec.b = rs2_data;
                if (funct7 == 7'b0000000) begin
                    dec_legal = 1'b1;
                    case (funct3)
                        3'b000:  dec.op = ALU_ADD;
                        3'b111:  dec.op = ALU_AND;
                        3'b110:  dec.op = ALU_OR;
                        default: dec_legal = 1'b0;
                    endcase
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    dec_legal = 1'b1;
                    dec.op    = ALU_SUB;
                end
            end
            OPC_IMM: begin
                dec.a     = rs1_data;
                dec.b     = imm_i;
                dec_legal = 1'b1;
                case (funct3)
                    3'b000:  dec.op = ALU_ADD;
                    3'b111:  dec.op = ALU_AND;
                    3'b110:  dec.op = ALU_OR;
                    default: dec_legal = 1'b0;
                endcase
            end
            OPC_LOAD: begin
                dec.a     = rs1_data;
                dec.b     = imm_i;
                dec_legal = (funct3 == 3'b010);
            end
            OPC_STORE: begin
                dec.a     = rs1_data;
                dec.b     = imm_s;
                dec_legal = (funct3 == 3'b010);
            end
            OPC_BRANCH: begin
                dec.a         = rs1_data;
                dec.b         = rs2_data;
                dec.op        = ALU_SUB;
                dec.is_branch = 1'b1;
                dec.br_ne     = funct3[0];
                dec_legal     = (funct3[2:1] == 2'b00);
            end
            default: ;
        endcase
        if (!dec_legal) begin
            dec.a         = '0;
            dec.b         = '0;
            dec.op        = ALU_AND;
            dec.is_branch = 1'b0;
            dec.br_ne     = 1'b0;
        end
        dec.illegal = ~dec_legal;
    end

    entry_t     mem [2];
    entry_t     head;
    logic       rd_ptr;
    logic       wr_ptr;
    logic [1:0] count;
    logic [1:0] count_next;
    logic       head_valid;
    logic       in_fire;
    logic       out_fire;
    logic       trap_state;
    logic       trap_state_next;

    assign head       = mem[rd_ptr];
    assign head_valid = (count != 2'd0);
    assign out_valid  = head_valid && !trap_state;
    assign in_fire    = in_valid && in_ready;
    assign out_fire   = out_valid && out_ready;

`ifdef ALU_ILLEGAL_TRAP_EN
    // Clear wins over a set arriving on the same edge so software can always unstick the stage.
    always_comb begin
        trap_state_next = trap_state;
        if (trap_clr) begin
            trap_state_next = 1'b0;
        end else if (out_fire && head.illegal) begin
            trap_state_next = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trap_state <= 1'b0;
        end else begin
            trap_state <= trap_state_next;
        end
    end

    assign trap = trap_state;
`else
    assign trap_state      = 1'b0;
    assign trap_state_next = 1'b0;
`endif

    always_comb begin
        count_next = count;
        case ({in_fire, out_fire})
            2'b10:   count_next = count + 2'd1;
            2'b01:   count_next = count - 2'd1;
            default: ;
        endcase
    end

    // in_ready is a flop fed from next-cycle occupancy, so the upstream never sees a combinational path from out_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= 2'd0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            in_ready <= 1'b0;
        end else begin
            count    <= count_next;
            in_ready <= (count_next != 2'd2) && !trap_state_next;
            if (in_fire) begin
                wr_ptr <= ~wr_ptr;
            end
            if (out_fire) begin
                rd_ptr <= ~rd_ptr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (in_fire) begin
            mem[wr_ptr] <= dec;
        end
    end

    // Fields read as zero whenever the buffer is empty so stale slots never leak out.
    always_comb begin
        alu_a     = '0;
        alu_b     = '0;
        alu_ctrl  = 4'b0000;
        rd_tag    = '0;
        is_branch = 1'b0;
        br_ne     = 1'b0;
        illegal   = 1'b0;
        if (head_valid) begin
            alu_a     = head.a;
            alu_b     = head.b;
            alu_ctrl  = head.op;
            rd_tag    = head.tag;
            is_branch = head.is_branch;
            br_ne     = head.br_ne;
            illegal   = head.illegal;
        end
    end

endmodule

// File: tb/tb_alu_issue_decoder.sv
// Self-checking bench for alu_issue_decoder: instruction-level reference model plus directed literal checks.
// Builds with or without ALU_ILLEGAL_TRAP_EN.
module tb_alu_issue_decoder;

    localparam int XLEN  = 32;
    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      inst = '0;
    logic [XLEN-1:0]  rs1_data = '0;
    logic [XLEN-1:0]  rs2_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [XLEN-1:0]  alu_a;
    logic [XLEN-1:0]  alu_b;
    logic [3:0]       alu_ctrl;
    logic [TAG_W-1:0] rd_tag;
    logic             is_branch;
    logic             br_ne;
    logic             illegal;
`ifdef ALU_ILLEGAL_TRAP_EN
    logic             trap;
    logic             trap_clr = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;

    alu_issue_decoder #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .inst      (inst),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_ctrl  (alu_ctrl),
        .rd_tag    (rd_tag),
        .is_branch (is_branch),
        .br_ne     (br_ne),
`ifdef ALU_ILLEGAL_TRAP_EN
        .trap      (trap),
        .trap_clr  (trap_clr),
`endif
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    typedef enum {M_ILL, M_ADD, M_SUB, M_AND, M_OR, M_ADDI, M_ANDI, M_ORI, M_LW, M_SW, M_BEQ, M_BNE} mnem_e;

    typedef struct {
        logic [XLEN-1:0]  a;
        logic [XLEN-1:0]  b;
        logic [3:0]       ctrl;
        logic [TAG_W-1:0] tag;
        logic             br;
        logic             ne;
        logic             ill;
    } entry_t;

    entry_t model_q[$];
    bit     model_primed = 1'b0;
    bit     model_trap   = 1'b0;

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Instruction-level reference: name the instruction first, then say what the ALU must see for it.
    function automatic entry_t golden(input logic [31:0] w, input logic [XLEN-1:0] r1, input logic [XLEN-1:0] r2);
        entry_t          e;
        mnem_e           m;
        logic [2:0]      f3;
        logic [6:0]      f7;
        logic [XLEN-1:0] imm_i;
        logic [XLEN-1:0] imm_s;
        f3    = w[14:12];
        f7    = w[31:25];
        imm_i = XLEN'($signed(w[31:20]));
        imm_s = XLEN'($signed({w[31:25], w[11:7]}));
        m     = M_ILL;
        case (w[6:0])
            7'h33: begin
                if (f7 == 7'h00 && f3 == 3'd0)      m = M_ADD;
                else if (f7 == 7'h20 && f3 == 3'd0) m = M_SUB;
                else if (f7 == 7'h00 && f3 == 3'd7) m = M_AND;
                else if (f7 == 7'h00 && f3 == 3'd6) m = M_OR;
            end
            7'h13: begin
                if (f3 == 3'd0)      m = M_ADDI;
                else if (f3 == 3'd7) m = M_ANDI;
                else if (f3 == 3'd6) m = M_ORI;
            end
            7'h03: if (f3 == 3'd2) m = M_LW;
            7'h23: if (f3 == 3'd2) m = M_SW;
            7'h63: begin
                if (f3 == 3'd0)      m = M_BEQ;
                else if (f3 == 3'd1) m = M_BNE;
            end
            default: ;
        endcase
        e.a    = '0;
        e.b    = '0;
        e.ctrl = 4'b0000;
        e.tag  = w[11:7];
        e.br   = 1'b0;
        e.ne   = 1'b0;
        e.ill  = (m == M_ILL);
        case (m)
            M_ADD:  begin e.a = r1; e.b = r2;    e.ctrl = 4'b0010; end
            M_SUB:  begin e.a = r1; e.b = r2;    e.ctrl = 4'b0110; end
            M_AND:  begin e.a = r1; e.b = r2;    e.ctrl = 4'b0000; end
            M_OR:   begin e.a = r1; e.b = r2;    e.ctrl = 4'b0001; end
            M_ADDI: begin e.a = r1; e.b = imm_i; e.ctrl = 4'b0010; end
            M_ANDI: begin e.a = r1; e.b = imm_i; e.ctrl = 4'b0000; end
            M_ORI:  begin e.a = r1; e.b = imm_i; e.ctrl = 4'b0001; end
            M_LW:   begin e.a = r1; e.b = imm_i; e.ctrl = 4'b0010; end
            M_SW:   begin e.a = r1; e.b = imm_s; e.ctrl = 4'b0010; end
            M_BEQ, M_BNE: begin
                e.a = r1; e.b = r2; e.ctrl = 4'b0110; e.br = 1'b1; e.ne = (m == M_BNE);
            end
            default: ;
        endcase
        return e;
    endfunction

    // Model update: a FIFO of decoded entries advanced by the handshakes it predicts itself.
    always @(posedge clk or posedge rst) begin : model_update
        bit rdy;
        bit vld;
        bit head_ill;
        if (rst) begin
            model_q.delete();
            model_primed = 1'b0;
            model_trap   = 1'b0;
        end else begin
            rdy      = model_primed && (model_q.size() < 2) && !model_trap;
            vld      = (model_q.size() > 0) && !model_trap;
            head_ill = vld ? model_q[0].ill : 1'b0;
            if (vld && out_ready) void'(model_q.pop_front());
            if (in_valid && rdy) model_q.push_back(golden(inst, rs1_data, rs2_data));
`ifdef ALU_ILLEGAL_TRAP_EN
            if (trap_clr) model_trap = 1'b0;
            else if (vld && out_ready && head_ill) model_trap = 1'b1;
`endif
            model_primed = 1'b1;
        end
    end

    // Compare on every falling edge, half a cycle away from the registered updates.
    always @(negedge clk) begin : compare
        entry_t h;
        if (rst) begin
            checkOutput("reset_outputs",
                        {in_ready, out_valid, alu_a, alu_b, alu_ctrl, rd_tag, is_branch, br_ne, illegal}, '0);
`ifdef ALU_ILLEGAL_TRAP_EN
            checkOutput("reset_trap", trap, 0);
`endif
        end else begin
            checkOutput("in_ready", in_ready, model_primed && (model_q.size() < 2) && !model_trap);
            checkOutput("out_valid", out_valid, (model_q.size() > 0) && !model_trap);
`ifdef ALU_ILLEGAL_TRAP_EN
            checkOutput("trap", trap, model_trap);
`endif
            if (model_q.size() > 0) begin
                h = model_q[0];
                checkOutput("alu_a", alu_a, h.a);
                checkOutput("alu_b", alu_b, h.b);
                checkOutput("alu_ctrl", alu_ctrl, h.ctrl);
                checkOutput("rd_tag", rd_tag, h.tag);
                checkOutput("is_branch", is_branch, h.br);
                checkOutput("br_ne", br_ne, h.ne);
                checkOutput("illegal", illegal, h.ill);
            end
        end
    end

    // Present one instruction and hold it until the stage takes it (bounded), then drop in_valid.
    task automatic applyStimulus(input logic [31:0] w, input logic [XLEN-1:0] r1, input logic [XLEN-1:0] r2);
        int budget;
        @(negedge clk);
        in_valid = 1'b1;
        inst     = w;
        rs1_data = r1;
        rs2_data = r2;
        budget   = 20;
        while (!in_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        checkOutput("accept_timeout", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic checkEntry(input string name, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                              input logic [3:0] ctrl, input logic [TAG_W-1:0] tag,
                              input logic br, input logic ne, input logic ill);
        checkOutput({name, "_valid"}, out_valid, 1);
        checkOutput({name, "_a"}, alu_a, a);
        checkOutput({name, "_b"}, alu_b, b);
        checkOutput({name, "_ctrl"}, alu_ctrl, ctrl);
        checkOutput({name, "_tag"}, rd_tag, tag);
        checkOutput({name, "_flags"}, {is_branch, br_ne, illegal}, {br, ne, ill});
    endtask

    function automatic logic [31:0] randomInst();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(6))
            0, 1: w[6:0] = 7'h33;
            2:    w[6:0] = 7'h13;
            3:    w[6:0] = 7'h03;
            4:    w[6:0] = 7'h23;
            5:    w[6:0] = 7'h63;
            default: ;
        endcase
        case ($urandom_range(3))
            0: w[14:12] = 3'd0;
            1: w[14:12] = 3'd7;
            2: w[14:12] = 3'd6;
            default: ;
        endcase
        if ($urandom_range(3) != 0) begin
            w[31:25] = $urandom_range(1) ? 7'h00 : 7'h20;
        end
        return w;
    endfunction

    initial begin
        $display("[TB] start");
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1 checkOutput("ready_after_reset", in_ready, 1);
        checkOutput("empty_after_reset", out_valid, 0);

        out_ready = 1'b1;
        applyStimulus(32'h002081B3, 32'd5, 32'd7);
        checkEntry("add", 32'd5, 32'd7, 4'b0010, 5'd3, 1'b0, 1'b0, 1'b0);
        applyStimulus(32'hFFF00093, 32'd0, 32'd9);
        checkEntry("addi", 32'd0, 32'hFFFFFFFF, 4'b0010, 5'd1, 1'b0, 1'b0, 1'b0);
        applyStimulus(32'hFE20AE23, 32'd100, 32'd9);
        checkEntry("sw", 32'd100, 32'hFFFFFFFC, 4'b0010, 5'd28, 1'b0, 1'b0, 1'b0);
        applyStimulus(32'h402081B3, 32'd20, 32'd3);
        checkEntry("sub", 32'd20, 32'd3, 4'b0110, 5'd3, 1'b0, 1'b0, 1'b0);
        applyStimulus(32'h00209463, 32'd4, 32'd6);
        checkEntry("bne", 32'd4, 32'd6, 4'b0110, 5'd8, 1'b1, 1'b1, 1'b0);
        applyStimulus(32'h0020F1B3, 32'hF0F0, 32'hFF00);
        checkEntry("and", 32'hF0F0, 32'hFF00, 4'b0000, 5'd3, 1'b0, 1'b0, 1'b0);
        applyStimulus(32'h0020E1B3, 32'h1, 32'h2);
        checkEntry("or", 32'h1, 32'h2, 4'b0001, 5'd3, 1'b0, 1'b0, 1'b0);

        // Back-pressure: three back-to-back ADDs with the consumer stalled.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1; inst = 32'h002081B3; rs1_data = 32'd11; rs2_data = 32'd1;
        checkOutput("bp_ready_0", in_ready, 1);
        @(negedge clk);
        rs1_data = 32'd22;
        checkOutput("bp_ready_1", in_ready, 1);
        checkOutput("bp_head_1", alu_a, 32'd11);
        @(negedge clk);
        rs1_data = 32'd33;
        checkOutput("bp_full", in_ready, 0);
        checkOutput("bp_head_2", alu_a, 32'd11);
        @(negedge clk);
        checkOutput("bp_still_full", in_ready, 0);
        checkOutput("bp_head_stable", alu_a, 32'd11);
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_second", alu_a, 32'd22);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("bp_third", alu_a, 32'd33);
        @(negedge clk);
        checkOutput("bp_drained", out_valid, 0);

        applyStimulus(32'h0000007F, 32'd9, 32'd9);
        checkEntry("bad_opcode", 32'd0, 32'd0, 4'b0000, 5'd0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
`ifdef ALU_ILLEGAL_TRAP_EN
        checkOutput("trap_set", trap, 1);
        checkOutput("trap_blocks_input", in_ready, 0);
        in_valid = 1'b1; inst = 32'h002081B3; rs1_data = 32'd44; rs2_data = 32'd2;
        @(negedge clk);
        checkOutput("trap_sticky", trap, 1);
        checkOutput("trap_still_blocked", in_ready, 0);
        trap_clr = 1'b1;
        @(negedge clk);
        trap_clr = 1'b0;
        checkOutput("trap_cleared", trap, 0);
        checkOutput("trap_ready_again", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("trap_resume_valid", out_valid, 1);
        checkOutput("trap_resume_a", alu_a, 32'd44);
`else
        checkOutput("illegal_no_stall", in_ready, 1);
        checkOutput("illegal_issued", out_valid, 0);
`endif

        // Reset with two entries parked in the buffer.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1; inst = 32'h002081B3; rs1_data = 32'd55;
        @(negedge clk);
        rs1_data = 32'd66;
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("parked_full", in_ready, 0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 checkOutput("rst_kills_valid", out_valid, 0);
        @(posedge clk);
        #2 rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 checkOutput("rst_ready_again", in_ready, 1);
        checkOutput("rst_no_stale", out_valid, 0);

        $display("[TB] random phase");
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(3) != 0);
            inst      = randomInst();
            rs1_data  = $urandom;
            rs2_data  = $urandom;
            out_ready = ($urandom_range(2) != 0);
`ifdef ALU_ILLEGAL_TRAP_EN
            trap_clr  = ($urandom_range(7) == 0);
`endif
        end

        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
`ifdef ALU_ILLEGAL_TRAP_EN
        trap_clr  = 1'b1;
`endif
        repeat (6) @(negedge clk);
        checkOutput("final_drained", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_issue_decoder.md
Name: alu_issue_decoder

Overview:
- Producer side of the single-cycle ALU interface: decodes a fetched RV32I instruction plus register-file operands into the ALU operand pair A/B and the 4-bit ALU control code.
- Registered issue stage with valid/ready handshakes on both sides and a 2-entry skid buffer, so the execute side can stall without dropping instructions.
- Sits between register-file read and the ALU; the destination register index travels with each entry as a tag.

Parameters:
- XLEN, 32, operand/data width.
- TAG_W, 5, width of the rd tag passed through with each instruction.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  instruction and operands valid.
- in_ready  out  1  stage can accept this cycle.
- inst  in  32  instruction word.
- rs1_data  in  XLEN  register-file read port 1.
- rs2_data  in  XLEN  register-file read port 2.
- out_valid  out  1  issued entry valid.
- out_ready  in  1  ALU/execute stage accepts entry.
- alu_a  out  XLEN  ALU operand A.
- alu_b  out  XLEN  ALU operand B.
- alu_ctrl  out  4  ALU control: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB.
- rd_tag  out  TAG_W  inst[11:7] passthrough.
- is_branch  out  1  entry is BEQ/BNE; execute uses zero flag.
- br_ne  out  1  1 = BNE (branch taken when zero==0), 0 = BEQ.
- illegal  out  1  entry did not decode.

Behaviour:
- Reset: all outputs 0; skid buffer empty; in_ready=1 on the first cycle after reset deassertion. Reset mid-transfer discards all held entries.
- Transfer rules: input transfer when in_valid&&in_ready; output transfer when out_valid&&out_ready.
- Latency: an accepted instruction appears at the outputs on the next rising edge (1 cycle) if the buffer is empty.
- Skid buffer: 2 entries, FIFO order.
  - in_ready = (occupancy < 2), registered.
  - out_valid = (occupancy > 0); output fields come from the head entry.
  - Simultaneous accept and issue leaves occupancy unchanged.
  - Full (2) with out_ready=0: in_ready=0 and the head is held stable.
  - Output fields must not change while out_valid=1 and out_ready=0.
- Decode by opcode inst[6:0], funct3 inst[14:12], funct7 inst[31:25]:
  - 0110011 R-type: A=rs1, B=rs2.
    - f3=000/f7=0000000 → 0010 (ADD).
    - f3=000/f7=0100000 → 0110 (SUB).
    - f3=111/f7=0 → 0000 (AND).
    - f3=110/f7=0 → 0001 (OR).
    - Anything else is illegal.
  - 0010011 I-type: A=rs1, B=sext(inst[31:20]).
    - f3=000 → ADD; 111 → AND; 110 → OR.
    - Others illegal.
  - 0000011 load (f3=010 only): A=rs1, B=sext(inst[31:20]), ADD.
  - 0100011 store (f3=010 only): A=rs1, B=sext({inst[31:25],inst[11:7]}), ADD.
  - 1100011 branch: A=rs1, B=rs2, SUB, is_branch=1.
    - f3=000 → br_ne=0; f3=001 → br_ne=1.
    - Other f3 illegal.
  - Any other opcode is illegal.
- Illegal entry: alu_ctrl=0000, alu_a=alu_b=0, is_branch=0, illegal=1; still consumes a buffer slot.
- Width: sign-extension is to XLEN from bit 31 of inst; no arithmetic is done here.

Optional Feature:
- Macro ALU_ILLEGAL_TRAP_EN.
- Defined:
  - Adds output port trap (1 bit) and input port trap_clr (1 bit).
  - The cycle an illegal entry is issued (output transfer), trap sets and stays set.
  - While trap=1, in_ready=0 and out_valid is forced 0; buffered entries are held.
  - trap_clr=1 clears trap on the next edge; trap_clr has priority over a new set.
  - Reset clears trap.
- Undefined: no trap/trap_clr ports; illegal entries flow through with illegal=1 and the pipeline never stalls on them.

Test Plan:
- Reset then ADD x3,x1,x2 (inst=0x002081B3, rs1=5, rs2=7), out_ready=1 → next cycle out_valid=1, alu_a=5, alu_b=7, alu_ctrl=0010, rd_tag=3, illegal=0.
- ADDI x1,x0,-1 (0xFFF00093), rs1=0 → alu_b=0xFFFFFFFF, alu_ctrl=0010; SW x2,-4(x1) (0xFE20AE23) → alu_b=0xFFFFFFFC.
- SUB (0x402081B3), BNE (0x00209463), AND (0x0020F1B3), OR (0x0020E1B3) → alu_ctrl 0110, 0110 (is_branch=1, br_ne=1), 0000, 0001.
- Back-pressure: out_ready=0, send 3 back-to-back instructions → first two accepted, in_ready=0 on the 3rd, outputs stable; raise out_ready → issued in order, no loss or duplication.
- inst=0x0000007F (bad opcode) → illegal=1, alu_ctrl=0000. With ALU_ILLEGAL_TRAP_EN: trap=1 after issue, in_ready=0; pulse trap_clr → trap=0, flow resumes.
- Assert rst with 2 entries buffered → immediately out_valid=0; after release, in_ready=1 and no stale entries are issued.
